div3_rr_sched: RTL
==================

# div3_rr_sched

Round-robin scheduler that shares one bit-serial divisible-by-3 residue engine among `NUM_REQ` requesters. Each requester presents a parallel `WIDTH`-bit word with a valid/ready handshake. The block grants one requester at a time and serializes the word MSB-first through an internal mod-3 residue state machine. It then returns the verdict, remainder and requester id on a valid/ready response port. It sits between parallel producers and the serial divisibility datapath, and owns both sequencing and arbitration of that datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range 1..16.
- `WIDTH`, default 8: bits per request word. Legal range 1..64.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0). Deassertion is synchronous to `clk` externally.
- `req_valid_i` in `NUM_REQ`: per-requester request valid.
- `req_data_i` in `NUM_REQ*WIDTH`: requester k's word is bits [k*WIDTH +: WIDTH].
- `req_ready_o` out `NUM_REQ`: one-hot-or-zero grant/accept. Handshake for requester k = `req_valid_i[k] & req_ready_o[k]`.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumer ready.
- `rsp_id_o` out `max(1,$clog2(NUM_REQ))`: index of the served requester.
- `rsp_div_o` out 1: 1 if the word is divisible by 3. A zero word counts as divisible.
- `rsp_rem_o` out 2: word mod 3, range 0..2.
- `busy_o` out 1: high in SHIFT and RESP.

## Operation
- FSM states:
  - IDLE: no word in flight.
  - SHIFT: serializing the captured word.
  - RESP: holding the result until the consumer accepts it.
- IDLE:
  - Grant is combinational. Starting from round-robin pointer `ptr`, search upward with wrap for the first `k` with `req_valid_i[k]=1`.
  - `req_ready_o[k]=1` only for that `k`; all other bits are 0.
  - If no request is valid, `req_ready_o=0`.
  - On the handshake edge: capture the word into the shift register, capture `k` into the id register, clear residue to 0, load the bit counter with `WIDTH`, set `ptr <= (k+1) mod NUM_REQ`, go to SHIFT.
- SHIFT:
  - Each edge consumes the MSB of the shift register: `r <= (2*r + bit) mod 3`, implemented as a 3-state transition (R0/R1/R2) with no divider.
  - Shift left by 1 and decrement the counter.
  - On the edge consuming the last bit (counter reaching 0), go to RESP.
  - `req_ready_o=0` throughout.
- RESP:
  - `rsp_valid_o=1`. `rsp_id_o`, `rsp_rem_o`, `rsp_div_o = (rem==0)` are stable and unchanged until the handshake.
  - On the edge with `rsp_ready_i=1`, go to IDLE.
  - `req_ready_o=0` throughout.
- `rsp_*` data outputs are registered, with no combinational path from `req_*` inputs.
- `req_valid_i` dropping without a handshake is legal; the arbiter re-evaluates every IDLE cycle.
- A request arriving during SHIFT/RESP waits; it is not lost, provided the requester holds valid.

## Timing
- Reset values: state=IDLE, `ptr=0`, `req_ready_o=0`, `rsp_valid_o=0`, `rsp_id_o=0`, `rsp_div_o=0`, `rsp_rem_o=0`, `busy_o=0`. Residue, counter and shift register are cleared.
- Latency: request handshake at edge E0 leads to `rsp_valid_o` high in the cycle following edge E0+`WIDTH`.
- Throughput with `rsp_ready_i` held high: one word per `WIDTH`+2 cycles.
  - The response handshake edge returns the FSM to IDLE.
  - The next grant is accepted at the following edge.
- Simultaneous valids: priority rotates. The requester just served has lowest priority next time.
- `NUM_REQ=1`: the grant is always requester 0, and `rsp_id_o` is a constant 0.
- `WIDTH=1`: SHIFT lasts exactly one edge.
- Reset mid-SHIFT or mid-RESP: the word in flight is discarded, no response is produced, and `ptr` returns to 0 immediately (asynchronously).
- The response is held indefinitely under backpressure. No further request is accepted while in RESP.

## Test plan
- Single requester 0, `WIDTH=8`, data 0x03, `rsp_ready_i=1`: `rsp_valid_o` high 9 cycles after the handshake edge, with `rsp_id_o=0`, `rsp_div_o=1`, `rsp_rem_o=0`.
- Value sweep on requester 2:
  - 0xFF: div=1, rem=0.
  - 0x64: div=0, rem=1.
  - 0x00: div=1, rem=0.
  - 0x05: div=0, rem=2.
  - In every case `rsp_id_o=2`.
- All four requesters valid continuously, data 3, 4, 5, 6: service order ids 0, 1, 2, 3, 0. Remainders 0, 1, 2, 0. Exactly one `req_ready_o` bit high per grant.
- Backpressure: `rsp_ready_i=0` for 20 cycles in RESP. `rsp_valid_o` and the data outputs stay stable, and `req_ready_o` stays 0 while requester 1 is valid. Releasing ready grants requester 1 on the next IDLE cycle.
- Reset asserted in the 4th SHIFT cycle: all outputs take their reset values immediately. After deassertion, no stale response appears, and a new request from requester 3 with data 0x09 yields id 3, div=1.
- Exhaustive: all 256 `WIDTH=8` words on random requesters, checked against a `% 3` model for both `rsp_rem_o` and `rsp_div_o`.

Source files
------------

// File: rtl/div3_rr_sched_if.sv
// Request/response bundle for the shared divisible-by-3 residue engine.
// The slave side is the scheduler; the master side is the producer/consumer environment.
interface div3_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [ID_W-1:0]          rsp_id_o;
  logic                     rsp_div_o;
  logic [1:0]               rsp_rem_o;
  logic                     busy_o;

  modport slave (
    input  req_valid_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_div_o, rsp_rem_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_div_o, rsp_rem_o, busy_o
  );
endinterface

// File: rtl/div3_rr_sched.sv
// Round-robin scheduler feeding one MSB-first bit-serial mod-3 residue engine.
// One word in flight at a time; the result is held until the consumer accepts it.
module div3_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input logic              clk,
  input logic              reset,
  div3_rr_sched_if.slave   bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2} res_t;

  // Appending bit b to a value with residue r gives residue (2r + b) mod 3.
  function automatic res_t res_step(input res_t r, input logic b);
    res_t n;
    case (r)
      R0:      n = b ? R1 : R0;
      R1:      n = b ? R0 : R2;
      R2:      n = b ? R2 : R1;
      default: n = R0;
    endcase
    return n;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;
  res_t               r_res;
  logic [ID_W-1:0]    r_id;
  logic [1:0]         r_rem;
  logic               r_div;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [ID_W-1:0]    w_idx;
  logic               w_found;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_hs;
  logic               w_last;
  res_t               w_res_nxt;

  // Search upward from the pointer with wrap; the first valid requester wins.
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_idx      = '0;
    w_found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && bus.req_valid_i[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx;
      end
    end
    w_grant[w_grant_id] = w_found;
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_id == ID_W'(k)) w_sel_data = bus.req_data_i[k*WIDTH +: WIDTH];
    end
  end

  assign bus.req_ready_o = (r_state == S_IDLE && reset) ? w_grant : '0;
  assign w_hs            = |(bus.req_valid_i & bus.req_ready_o);
  assign w_last          = (r_cnt == CNT_W'(1));
  assign w_res_nxt       = res_step(r_res, r_shift[WIDTH-1]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_res   <= R0;
      r_id    <= '0;
      r_rem   <= '0;
      r_div   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_shift <= w_sel_data;
            r_id    <= w_grant_id;
            r_res   <= R0;
            r_cnt   <= CNT_W'(WIDTH);
            r_ptr   <= ID_W'((int'(w_grant_id) + 1) % NUM_REQ);
          end
        end
        S_SHIFT: begin
          r_res   <= w_res_nxt;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - CNT_W'(1);
          // Result registers load only on the final bit so they stay stable through RESP.
          if (w_last) begin
            r_rem <= w_res_nxt;
            r_div <= (w_res_nxt == R0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid_o = (r_state == S_RESP);
  assign bus.rsp_id_o    = r_id;
  assign bus.rsp_rem_o   = r_rem;
  assign bus.rsp_div_o   = r_div;
  assign bus.busy_o      = (r_state != S_IDLE);
endmodule
